// File: rtl/sa_tile_sequencer.sv
// Sequences one output-stationary NxN MAC tile: clear, skewed operand feed, drain, row-major readout.
// Optional feature macro SA_SEQ_ABORT_EN adds abort/aborted to cancel a running tile.
`timescale 1ns/1ps
module sa_tile_sequencer #(
  parameter int N     = 8,
  parameter int DW    = 8,
  parameter int ACC_W = 32,
  parameter int KW    = 8
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  input  logic [KW-1:0]         k_len,
  output logic                  busy,
  output logic                  done,
  input  logic                  op_valid,
  output logic                  op_ready,
  input  logic [N*DW-1:0]       op_act,
  input  logic [N*DW-1:0]       op_wgt,
  output logic                  arr_clear,
  output logic [N*DW-1:0]       arr_act,
  output logic [N*DW-1:0]       arr_wgt,
  output logic [$clog2(N)-1:0]  rd_row,
  output logic [$clog2(N)-1:0]  rd_col,
  input  logic [ACC_W-1:0]      rd_data,
  output logic                  res_valid,
  input  logic                  res_ready,
  output logic [ACC_W-1:0]      res_data,
  output logic                  res_last
`ifdef SA_SEQ_ABORT_EN
  ,
  input  logic                  abort,
  output logic                  aborted
`endif
);

  localparam int IW        = $clog2(N);
  localparam int DRAIN_CYC = 2 * N - 1;
  localparam int DCW       = $clog2(2 * N);

  typedef enum logic [2:0] {S_IDLE, S_CLEAR, S_FEED, S_DRAIN, S_READ} state_t;

  state_t          state_q, state_d;
  logic [KW-1:0]   k_len_q, k_len_d;
  logic [KW-1:0]   beat_q, beat_d;
  logic [DCW-1:0]  drain_q, drain_d;
  logic [IW-1:0]   row_q, row_d, col_q, col_d;
  logic            busy_q, busy_d;
  logic            done_q, done_d;
  logic            op_ready_q, op_ready_d;
  logic            arr_clear_q, arr_clear_d;
  logic            res_valid_q, res_valid_d;
  logic            res_last_q, res_last_d;
  logic            accept, res_hs, abort_hit;

`ifdef SA_SEQ_ABORT_EN
  logic            aborted_q, aborted_d;
  assign abort_hit = abort && (state_q != S_IDLE);
  assign aborted   = aborted_q;
`else
  assign abort_hit = 1'b0;
`endif

  assign accept = op_valid && op_ready_q;
  assign res_hs = res_valid_q && res_ready;

  always_comb begin
    state_d = state_q;
    k_len_d = k_len_q;
    beat_d  = beat_q;
    drain_d = drain_q;
    row_d   = row_q;
    col_d   = col_q;
    done_d  = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          k_len_d = k_len;
          state_d = S_CLEAR;
        end
      end
      S_CLEAR: begin
        beat_d  = '0;
        drain_d = '0;
        state_d = (k_len_q == '0) ? S_DRAIN : S_FEED;
      end
      S_FEED: begin
        if (accept) begin
          beat_d = beat_q + KW'(1);
          if (beat_q + KW'(1) == k_len_q) state_d = S_DRAIN;
        end
      end
      S_DRAIN: begin
        drain_d = drain_q + DCW'(1);
        if (drain_q == DCW'(DRAIN_CYC - 1)) begin
          state_d = S_READ;
          row_d   = '0;
          col_d   = '0;
        end
      end
      S_READ: begin
        if (res_hs) begin
          col_d = col_q + IW'(1);
          if (col_q == IW'(N - 1)) row_d = row_q + IW'(1);
          if (row_q == IW'(N - 1) && col_q == IW'(N - 1)) begin
            state_d = S_IDLE;
            done_d  = 1'b1;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
    if (abort_hit) begin
      state_d = S_IDLE;
      row_d   = '0;
      col_d   = '0;
    end
`ifdef SA_SEQ_ABORT_EN
    aborted_d = abort_hit;
`endif
    // Outputs are registered copies decoded from the next state.
    busy_d      = (state_d != S_IDLE);
    op_ready_d  = (state_d == S_FEED);
    res_valid_d = (state_d == S_READ);
    res_last_d  = (state_d == S_READ) && (row_d == IW'(N - 1)) && (col_d == IW'(N - 1));
    arr_clear_d = (state_d == S_CLEAR) || abort_hit;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= S_IDLE;
      k_len_q     <= '0;
      beat_q      <= '0;
      drain_q     <= '0;
      row_q       <= '0;
      col_q       <= '0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      op_ready_q  <= 1'b0;
      arr_clear_q <= 1'b0;
      res_valid_q <= 1'b0;
      res_last_q  <= 1'b0;
`ifdef SA_SEQ_ABORT_EN
      aborted_q   <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      k_len_q     <= k_len_d;
      beat_q      <= beat_d;
      drain_q     <= drain_d;
      row_q       <= row_d;
      col_q       <= col_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      op_ready_q  <= op_ready_d;
      arr_clear_q <= arr_clear_d;
      res_valid_q <= res_valid_d;
      res_last_q  <= res_last_d;
`ifdef SA_SEQ_ABORT_EN
      aborted_q   <= aborted_d;
`endif
    end
  end

  // Lane i sees i stages of delay, so beat t meets PE(r,c) on cycle t+r+c.
  for (genvar i = 0; i < N; i++) begin : g_skew
    logic [DW-1:0] act_in, wgt_in;
    assign act_in = accept ? op_act[i*DW +: DW] : '0;
    assign wgt_in = accept ? op_wgt[i*DW +: DW] : '0;
    if (i == 0) begin : g_direct
      assign arr_act[DW-1:0] = act_in;
      assign arr_wgt[DW-1:0] = wgt_in;
    end else begin : g_pipe
      logic [DW-1:0] act_sr_q [0:i-1];
      logic [DW-1:0] act_sr_d [0:i-1];
      logic [DW-1:0] wgt_sr_q [0:i-1];
      logic [DW-1:0] wgt_sr_d [0:i-1];
      always_comb begin
        for (int s = 0; s < i; s++) begin
          act_sr_d[s] = (s == 0) ? act_in : act_sr_q[(s == 0) ? 0 : s - 1];
          wgt_sr_d[s] = (s == 0) ? wgt_in : wgt_sr_q[(s == 0) ? 0 : s - 1];
          if (abort_hit) begin
            act_sr_d[s] = '0;
            wgt_sr_d[s] = '0;
          end
        end
      end
      always_ff @(posedge clk) begin
        for (int s = 0; s < i; s++) begin
          if (reset) begin
            act_sr_q[s] <= '0;
            wgt_sr_q[s] <= '0;
          end else begin
            act_sr_q[s] <= act_sr_d[s];
            wgt_sr_q[s] <= wgt_sr_d[s];
          end
        end
      end
      assign arr_act[i*DW +: DW] = act_sr_q[i-1];
      assign arr_wgt[i*DW +: DW] = wgt_sr_q[i-1];
    end
  end

  assign busy      = busy_q;
  assign done      = done_q;
  assign op_ready  = op_ready_q;
  assign arr_clear = arr_clear_q || reset;
  assign rd_row    = row_q;
  assign rd_col    = col_q;
  assign res_valid = res_valid_q;
  assign res_data  = res_valid_q ? rd_data : '0;
  assign res_last  = res_last_q;

endmodule
